// File: rtl/adc_delay_cal.sv
`default_nettype none
// ============================================================================
//  Module   : adc_delay_cal
//  Purpose  : Per-lane IDELAY tap sweep against an alternating training
//             pattern; finds the longest passing window per lane and parks
//             the delay element at its center.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_delay_cal #(
    parameter  int WIDTH   = 8,
    parameter  int TAPS    = 32,
    parameter  int SETTLE  = 16,
    parameter  int SAMPLES = 64,
    localparam int c_TAPW  = (TAPS  > 1) ? $clog2(TAPS)  : 1,
    localparam int c_LSW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  data,
    output logic [c_LSW-1:0]  lane_sel,
    output logic              dly_rst,
    output logic              dly_ce,
    output logic [c_TAPW-1:0] tap,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  lane_err
);

    localparam int c_CNTMAX = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
    localparam int c_CNTW   = $clog2(c_CNTMAX + 1);

    localparam logic [c_CNTW-1:0] c_SETTLE_LAST  = c_CNTW'(SETTLE - 1);
    localparam logic [c_CNTW-1:0] c_SAMPLES_LAST = c_CNTW'(SAMPLES - 1);
    localparam logic [c_TAPW-1:0] c_TAP_LAST     = c_TAPW'(TAPS - 1);
    localparam logic [c_LSW-1:0]  c_LANE_LAST    = c_LSW'(WIDTH - 1);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_DRST     = 4'd1;
    localparam logic [3:0] c_SETTLE   = 4'd2;
    localparam logic [3:0] c_CHECK    = 4'd3;
    localparam logic [3:0] c_STEP     = 4'd4;
    localparam logic [3:0] c_EVAL     = 4'd5;
    localparam logic [3:0] c_SEEK_RST = 4'd6;
    localparam logic [3:0] c_SEEK     = 4'd7;
    localparam logic [3:0] c_NEXT     = 4'd8;
    localparam logic [3:0] c_DONE     = 4'd9;

    logic [3:0]        r_state;
    logic [c_LSW-1:0]  r_lane_sel;
    logic [c_TAPW-1:0] r_tap;
    logic [c_TAPW-1:0] r_center;
    logic [c_CNTW-1:0] r_cnt;
    logic              r_dly_rst;
    logic              r_dly_ce;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_lane_err;
    logic              r_prev;
    logic              r_fail;
    logic [c_TAPW-1:0] r_run_start;
    logic [c_TAPW:0]   r_run_len;
    logic [c_TAPW-1:0] r_best_start;
    logic [c_TAPW:0]   r_best_len;

    logic              w_bit;
    logic              w_fail;
    logic [c_TAPW-1:0] w_run_start;
    logic [c_TAPW:0]   w_run_next;
    logic [c_TAPW-1:0] w_center;
    logic [c_TAPW-1:0] w_tap_inc;

    // A healthy lane toggles every clock, so matching the previous sample is a bit error.
    assign w_bit       = data[r_lane_sel];
    assign w_fail      = r_fail | (w_bit == r_prev);
    assign w_run_start = (r_run_len == '0) ? r_tap : r_run_start;
    assign w_run_next  = r_run_len + (c_TAPW + 1)'(1);
    assign w_center    = r_best_start + r_best_len[c_TAPW:1];
    assign w_tap_inc   = r_tap + c_TAPW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_lane_sel   <= '0;
            r_tap        <= '0;
            r_center     <= '0;
            r_cnt        <= '0;
            r_dly_rst    <= 1'b0;
            r_dly_ce     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_lane_err   <= '0;
            r_prev       <= 1'b0;
            r_fail       <= 1'b0;
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else begin
            r_prev    <= w_bit;
            r_dly_rst <= 1'b0;
            r_dly_ce  <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state    <= c_DRST;
                        r_lane_sel <= '0;
                        r_lane_err <= '0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_dly_rst  <= 1'b1;
                    end
                end
                c_DRST: begin
                    r_tap        <= '0;
                    r_run_start  <= '0;
                    r_run_len    <= '0;
                    r_best_start <= '0;
                    r_best_len   <= '0;
                    r_cnt        <= '0;
                    r_state      <= c_SETTLE;
                end
                c_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_fail  <= 1'b0;
                        r_state <= c_CHECK;
                    end else begin
                        r_cnt <= r_cnt + c_CNTW'(1);
                    end
                end
                c_CHECK: begin
                    r_fail <= w_fail;
                    if (r_cnt == c_SAMPLES_LAST) begin
                        r_cnt <= '0;
                        if (w_fail) begin
                            r_run_len <= '0;
                        end else begin
                            r_run_start <= w_run_start;
                            r_run_len   <= w_run_next;
                            // Strict compare keeps the earliest of equally long windows.
                            if (w_run_next > r_best_len) begin
                                r_best_start <= w_run_start;
                                r_best_len   <= w_run_next;
                            end
                        end
                        if (r_tap != c_TAP_LAST) begin
                            r_state  <= c_STEP;
                            r_dly_ce <= 1'b1;
                        end else begin
                            r_state <= c_EVAL;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNTW'(1);
                    end
                end
                c_STEP: begin
                    r_tap   <= w_tap_inc;
                    r_state <= c_SETTLE;
                end
                c_EVAL: begin
                    if (r_best_len == '0) begin
                        r_lane_err[r_lane_sel] <= 1'b1;
                        r_center               <= '0;
                    end else begin
                        r_center <= w_center;
                    end
                    r_dly_rst <= 1'b1;
                    r_state   <= c_SEEK_RST;
                end
                c_SEEK_RST: begin
                    r_tap    <= '0;
                    r_dly_ce <= (r_center != '0);
                    r_state  <= c_SEEK;
                end
                c_SEEK: begin
                    if (r_tap == r_center) begin
                        r_state <= c_NEXT;
                    end else begin
                        r_tap    <= w_tap_inc;
                        r_dly_ce <= (w_tap_inc != r_center);
                    end
                end
                c_NEXT: begin
                    if (r_lane_sel == c_LANE_LAST) begin
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_lane_sel <= r_lane_sel + c_LSW'(1);
                        r_dly_rst  <= 1'b1;
                        r_state    <= c_DRST;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign lane_sel = r_lane_sel;
    assign dly_rst  = r_dly_rst;
    assign dly_ce   = r_dly_ce;
    assign tap      = r_tap;
    assign busy     = r_busy;
    assign done     = r_done;
    assign lane_err = r_lane_err;

endmodule
`default_nettype wire
